// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
//   Shared definitions for the single-master I2C controller:
//   - ADDR_W / DATA_W : fixed slave address width and data word width
//   - IDLE..STOP      : 4-bit FSM state codes (0..9), also observed by the bench
//   - byte_end()      : true on the last bit of a byte (index 8 or 0)
//   - more_bytes()    : true when a second byte still follows the current one
// -----------------------------------------------------------------------------
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 16;

  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] START      = 4'd1;
  localparam logic [3:0] ADDR       = 4'd2;
  localparam logic [3:0] RW         = 4'd3;
  localparam logic [3:0] ADDR_ACK   = 4'd4;
  localparam logic [3:0] WRITE_DATA = 4'd5;
  localparam logic [3:0] WRITE_ACK  = 4'd6;
  localparam logic [3:0] READ_DATA  = 4'd7;
  localparam logic [3:0] MASTER_ACK = 4'd8;
  localparam logic [3:0] STOP       = 4'd9;

  // Bit indices run 15..8 then 7..0 (2-byte) or 7..0 (1-byte), so a byte
  // finishes whenever the index being transferred is 8 or 0.
  function automatic logic byte_end(input logic [3:0] cnt);
    return (cnt == 4'd8) || (cnt == 4'd0);
  endfunction

  // After the first byte of a 2-byte transfer the index has dropped to 7;
  // after the last byte it has wrapped to 15.
  function automatic logic more_bytes(input logic two, input logic [3:0] cnt);
    return two && (cnt == 4'd7);
  endfunction

endpackage

// File: rtl/i2c_master.sv
// -----------------------------------------------------------------------------
// i2c_master
//   Single-master I2C controller. One start pulse issues one transaction:
//   START, 7-bit address, R/W, one or two data bytes (each followed by an
//   ACK phase), STOP. One I2C bit is transferred per clk cycle.
//
//   Ports
//     clk        in     system clock
//     rst        in     asynchronous, active-low reset
//     start      in     transaction request, accepted only while ready=1
//     rw         in     0=write, 1=read (latched on start)
//     addr[6:0]  in     slave address (latched on start)
//     data[15:0] in     write data (latched on start)
//     two_bytes  in     1=2-byte transfer, 0=1-byte (latched on start)
//     ready      out    idle and able to accept start
//     read_data  out    read result, updated bit by bit during reads
//     scl        out    I2C clock: 1 in IDLE/START/STOP, ~clk otherwise
//     sda        inout  I2C data, open-drain (drives 0 or releases)
//     ack_err    out    only with I2C_ACK_ERR_EN defined: sticky slave-NACK
//                       flag, cleared when a start is accepted
//
//   Build option: define I2C_ACK_ERR_EN to add the ack_err output.
// -----------------------------------------------------------------------------
module i2c_master
  import i2c_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              two_bytes,
  output logic              ready,
  output logic [DATA_W-1:0] read_data,
  output logic              scl,
`ifdef I2C_ACK_ERR_EN
  output logic              ack_err,
`endif
  inout  wire               sda
);

  logic [3:0]        state, state_d;
  logic [3:0]        count, count_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              rw_q;
  logic              two_q;
  logic [DATA_W-1:0] read_data_q;
  logic              sda_low;
  logic              scl_hi;
  logic              sda_ack;

  // Only a solid 0 is an ACK; a released (pulled-up or floating) line is NACK.
  assign sda_ack = (sda == 1'b0);

  // State register and bit index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= state_d;
      count <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    count_d = count;
    case (state)
      IDLE: begin
        if (start) state_d = START;
      end
      START: begin
        count_d = 4'd6;
        state_d = ADDR;
      end
      ADDR: begin
        count_d = count - 4'd1;
        if (count == 4'd0) state_d = RW;
      end
      RW: begin
        count_d = two_q ? 4'd15 : 4'd7;
        state_d = ADDR_ACK;
      end
      ADDR_ACK: begin
        if (sda_ack) state_d = rw_q ? READ_DATA : WRITE_DATA;
        else         state_d = STOP;
      end
      WRITE_DATA: begin
        count_d = count - 4'd1;
        if (byte_end(count)) state_d = WRITE_ACK;
      end
      WRITE_ACK: begin
        if (sda_ack && more_bytes(two_q, count)) state_d = WRITE_DATA;
        else                                     state_d = STOP;
      end
      READ_DATA: begin
        count_d = count - 4'd1;
        if (byte_end(count)) state_d = MASTER_ACK;
      end
      MASTER_ACK: begin
        state_d = more_bytes(two_q, count) ? READ_DATA : STOP;
      end
      STOP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    sda_low = 1'b0;
    scl_hi  = 1'b0;
    case (state)
      IDLE:       scl_hi = 1'b1;
      START: begin
        scl_hi  = 1'b1;
        sda_low = 1'b1;
      end
      ADDR:       sda_low = ~addr_q[count[2:0]];
      RW:         sda_low = ~rw_q;
      WRITE_DATA: sda_low = ~data_q[count];
      // Master ACKs every byte but the last; the final NACK ends the read.
      MASTER_ACK: sda_low = more_bytes(two_q, count);
      // STOP holds sda low with scl high; IDLE then releases it, which
      // produces the rising STOP edge.
      STOP: begin
        scl_hi  = 1'b1;
        sda_low = 1'b1;
      end
      default: begin
        sda_low = 1'b0;
        scl_hi  = 1'b0;
      end
    endcase
  end

  assign ready     = (state == IDLE);
  assign scl       = scl_hi ? 1'b1 : ~clk;
  assign sda       = sda_low ? 1'b0 : 1'bz;
  assign read_data = read_data_q;

  // Transaction parameters are captured once so later input changes are inert.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      addr_q <= addr;
      data_q <= data;
      rw_q   <= rw;
      two_q  <= two_bytes;
    end
  end

  // Read shift-in; a 1-byte read clears the stale upper byte on its first bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data_q <= '0;
    end else if (state == READ_DATA) begin
      if (!two_q && count == 4'd7) read_data_q[15:8] <= 8'h00;
      read_data_q[count] <= sda;
    end
  end

`ifdef I2C_ACK_ERR_EN
  logic ack_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_err_q <= 1'b0;
    end else if (state == IDLE && start) begin
      ack_err_q <= 1'b0;
    end else if ((state == ADDR_ACK || state == WRITE_ACK) && !sda_ack) begin
      ack_err_q <= 1'b1;
    end
  end

  assign ack_err = ack_err_q;
`endif

endmodule

// File: tb/tb_i2c_master.sv
// -----------------------------------------------------------------------------
// tb_i2c_master
//   Self-checking bench for i2c_master. A table of directed transactions and a
//   set of random ones are run against a frame model that lays out the expected
//   bus activity (state, sda level) cycle by cycle from the protocol rules and
//   acts as the slave. Hand-written sequences cover reset behaviour, including
//   a reset in the middle of a write.
// -----------------------------------------------------------------------------
module tb_i2c_master;

  logic        clk;
  logic        rst;
  logic        start;
  logic        rw;
  logic [6:0]  addr;
  logic [15:0] data;
  logic        two_bytes;
  logic        ready;
  logic [15:0] read_data;
  logic        scl;
  logic        slave_low;
  wire         sda;
`ifdef I2C_ACK_ERR_EN
  logic        ack_err;
`endif

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  i2c_master dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rw        (rw),
    .addr      (addr),
    .data      (data),
    .two_bytes (two_bytes),
    .ready     (ready),
    .read_data (read_data),
    .scl       (scl),
`ifdef I2C_ACK_ERR_EN
    .ack_err   (ack_err),
`endif
    .sda       (sda)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        rw;
    bit [6:0]  addr;
    bit [15:0] data;
    bit        two;
    bit        ack_a;    // slave ACKs the address
    bit        ack0;     // slave ACKs first written byte
    bit        ack1;     // slave ACKs second written byte
    bit [15:0] rd;       // bytes the slave returns (high byte first)
    int        exp_len;  // busy cycles from START through STOP
    bit [15:0] exp_rd;   // read_data after the transaction
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Frame model output: one entry per busy cycle.
  int        q_st[$];
  bit        q_sda[$];
  bit        q_slv[$];
  bit [15:0] m_rd = 16'h0000;
  bit        m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic put(input int st, input bit lvl, input bit slv);
    q_st.push_back(st);
    q_sda.push_back(lvl);
    q_slv.push_back(slv);
  endtask

  task automatic build_model(input vec_t v);
    int       nb;
    bit [7:0] by;
    bit       ack;
    bit       halt;
    q_st.delete();
    q_sda.delete();
    q_slv.delete();
    m_err = 1'b0;
    put(1, 1'b0, 1'b0);
    for (int b = 6; b >= 0; b--) put(2, v.addr[b], 1'b0);
    put(3, v.rw, 1'b0);
    put(4, !v.ack_a, v.ack_a);
    if (!v.ack_a) begin
      m_err = 1'b1;
    end else begin
      nb   = v.two ? 2 : 1;
      halt = 1'b0;
      for (int j = 0; j < nb && !halt; j++) begin
        if (v.rw) by = (nb == 2 && j == 0) ? v.rd[15:8]   : v.rd[7:0];
        else      by = (nb == 2 && j == 0) ? v.data[15:8] : v.data[7:0];
        for (int b = 7; b >= 0; b--) put(v.rw ? 7 : 5, by[b], v.rw && !by[b]);
        if (v.rw) begin
          put(8, (j == nb - 1), 1'b0);
        end else begin
          ack = (j == 0) ? v.ack0 : v.ack1;
          put(6, !ack, ack);
          if (!ack) begin
            m_err = 1'b1;
            halt  = 1'b1;
          end
        end
      end
      if (v.rw) m_rd = v.two ? v.rd : {8'h00, v.rd[7:0]};
    end
    put(9, 1'b0, 1'b0);
  endtask

  task automatic run_txn(input vec_t v, input string tag, input bit use_tbl);
    int len;
    int n;
    bit done;
    int st;
    build_model(v);
    len = q_st.size();
    @(negedge clk);
    chk($sformatf("%s ready before start", tag), ready, 1'b1);
    rw = v.rw; addr = v.addr; data = v.data; two_bytes = v.two;
    start = 1'b1; slave_low = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    done = 1'b0;
    n = -1;
    for (int i = 0; i < 48 && !done; i++) begin
      slave_low = (i < len) ? q_slv[i] : 1'b0;
      // Scramble inputs (including stray start pulses) while busy.
      if (i < len - 1) begin
        start = 1'($urandom); rw = 1'($urandom); addr = 7'($urandom);
        data = 16'($urandom); two_bytes = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      if (i < len) begin
        st = q_st[i];
        chk($sformatf("%s scl c%0d", tag, i), scl, (st == 1 || st == 9) ? 1'b1 : 1'b0);
      end
      @(negedge clk);
      if (ready) begin
        done = 1'b1;
        n = i;
      end else if (i < len) begin
        chk($sformatf("%s state c%0d", tag, i), dut.state, q_st[i]);
        chk($sformatf("%s sda c%0d", tag, i), sda, q_sda[i]);
      end
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    slave_low = 1'b0;
    start = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: ready still 0 after 48 cycles, required within %0d", tag, len);
    end else begin
      chk($sformatf("%s busy cycles", tag), n, use_tbl ? v.exp_len : len);
      chk($sformatf("%s read_data", tag), read_data, use_tbl ? v.exp_rd : m_rd);
      chk($sformatf("%s idle state", tag), dut.state, 0);
      chk($sformatf("%s idle sda", tag), sda, 1'b1);
`ifdef I2C_ACK_ERR_EN
      chk($sformatf("%s ack_err", tag), ack_err, m_err);
`endif
    end
  endtask

  vec_t tbl[8];
  vec_t rv;
  int   k;

  initial begin
    //        rw  addr    data       two  acka ack0 ack1 rd         len exp_rd
    tbl[0] = '{1'b0, 7'h50, 16'hAA55, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 11, 16'h0000};
    tbl[1] = '{1'b0, 7'h50, 16'hAA55, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 20, 16'h0000};
    tbl[2] = '{1'b1, 7'h50, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00A0, 20, 16'h00A0};
    tbl[3] = '{1'b0, 7'h50, 16'hAA55, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 29, 16'h00A0};
    tbl[4] = '{1'b1, 7'h50, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'hA0A0, 29, 16'hA0A0};
    tbl[5] = '{1'b1, 7'h2B, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h375A, 20, 16'h005A};
    tbl[6] = '{1'b0, 7'h7F, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 20, 16'h005A};
    tbl[7] = '{1'b1, 7'h01, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF, 11, 16'h005A};

    rst = 1'b0; start = 1'b0; rw = 1'b0; addr = '0; data = '0;
    two_bytes = 1'b0; slave_low = 1'b0;

    // Reset state
    #12;
    chk("reset state", dut.state, 0);
    chk("reset count", dut.count, 0);
    chk("reset ready", ready, 1'b1);
    chk("reset scl", scl, 1'b1);
    chk("reset sda", sda, 1'b1);
    chk("reset read_data", read_data, 16'h0000);
`ifdef I2C_ACK_ERR_EN
    chk("reset ack_err", ack_err, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // Directed table
    for (int r = 0; r < 8; r++) run_txn(tbl[r], $sformatf("tbl%0d", r), 1'b1);

    // Random transactions against the frame model
    for (int r = 0; r < 40; r++) begin
      rv.rw    = 1'($urandom);
      rv.addr  = 7'($urandom);
      rv.data  = 16'($urandom);
      rv.two   = 1'($urandom);
      rv.ack_a = ($urandom_range(0, 7) != 0);
      rv.ack0  = ($urandom_range(0, 5) != 0);
      rv.ack1  = ($urandom_range(0, 5) != 0);
      rv.rd    = 16'($urandom);
      rv.exp_len = 0;
      rv.exp_rd  = 16'h0000;
      run_txn(rv, $sformatf("rnd%0d", r), 1'b0);
    end

    // Reset asserted during WRITE_DATA aborts at once
    @(negedge clk);
    rw = 1'b0; addr = 7'h50; data = 16'hAA55; two_bytes = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (dut.state != 4'd5 && k < 30) begin
      slave_low = (dut.state == 4'd4);
      @(posedge clk); #1;
      k++;
    end
    slave_low = 1'b0;
    chk("mid reached WRITE_DATA", dut.state, 5);
    #2 rst = 1'b0;
    #1;
    chk("mid reset state", dut.state, 0);
    chk("mid reset scl", scl, 1'b1);
    chk("mid reset sda", sda, 1'b1);
    chk("mid reset ready", ready, 1'b1);
    chk("mid reset read_data", read_data, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    m_rd = 16'h0000;
    @(negedge clk);
    chk("post reset state", dut.state, 0);

    // A normal transaction after the abort
    run_txn(tbl[1], "post_rst_write", 1'b1);
    rv = '{1'b1, 7'h3C, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'hC35A, 0, 16'h0000};
    run_txn(rv, "post_rst_read", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
